// File: rtl/bl_encoder.sv
// bl_encoder: backscatter-link FM0/Miller frame encoder that advances only on sample strobes.
// Define BL_ENCODER_CRC16_EN to append an inverted CRC-16 trailer after the data bits.
module bl_encoder #(
    parameter int HALF_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  strobe,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  trext,
    input  logic [HALF_WIDTH-1:0] half_len,
    input  logic                  in_bit,
    input  logic                  in_vld,
    input  logic                  in_last,
    output logic                  in_rdy,
    output logic                  out_bl,
    output logic                  busy,
    output logic                  underrun
);
`ifdef BL_ENCODER_CRC16_EN
    typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, CRC, DUMMY} state_t;
`else
    typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, DUMMY} state_t;
`endif
    localparam logic [11:0] FM0_PRE = 12'b110100100100;
    localparam logic [5:0]  MIL_PRE = 6'b010111;
    state_t state, state_nxt;
    logic [1:0] mode_q;
    logic trext_q, lv, prev, dbit, dlast;
    logic [HALF_WIDTH-1:0] hl_q;
    logic [CNT_WIDTH-1:0] scnt, hcnt, sym, hl_m1, hmid, hmax, plen_m1;
    logic fm0, accept, last_smp, sym_end, d, inv, lv_n, sample, take, urun;
    logic [3:0] pidx;
    logic [2:0] midx;
`ifdef BL_ENCODER_CRC16_EN
    logic [15:0] crc;
    logic [3:0] cidx;
`endif
    // hcnt counts half BLF cycles inside a symbol; hmid marks the mid-symbol point
    always_comb begin
        fm0 = mode_q == 2'b00;
        accept = start && !busy;
        hl_m1 = CNT_WIDTH'(hl_q) - CNT_WIDTH'(1);
        hmid = CNT_WIDTH'(1) << mode_q;
        hmax = (hmid << 1) - CNT_WIDTH'(1);
        plen_m1 = fm0 ? CNT_WIDTH'(11) : trext_q ? CNT_WIDTH'(15) : CNT_WIDTH'(3);
        last_smp = scnt == hl_m1;
        sym_end = last_smp && hcnt == hmax;
        pidx = 4'd11 - {sym[2:0], hcnt[0]};
        midx = 3'd5 - sym[2:0];
        d = state == DATA ? dbit : state == PREAMBLE ? MIL_PRE[midx] : state != PILOT;
`ifdef BL_ENCODER_CRC16_EN
        cidx = 4'd15 - sym[3:0];
        if (state == CRC)
            d = ~crc[cidx];
`endif
        inv = scnt != '0 ? 1'b0 : hcnt == '0 ? (fm0 || (!prev && !d)) : (hcnt == hmid && (fm0 ? !d : d));
        lv_n = lv ^ inv;
        sample = fm0 ? (state == PREAMBLE ? FM0_PRE[pidx] : lv_n) : lv_n ^ !hcnt[0];
        in_rdy = sym_end && (state == PREAMBLE ? sym == CNT_WIDTH'(5) : state == DATA && !dlast);
        take = in_rdy && strobe && in_vld;
        urun = in_rdy && strobe && !in_vld;
    end
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = (mode == 2'b00 && !trext) ? PREAMBLE : PILOT;
        else if (strobe && sym_end)
            case (state)
                PILOT:    if (sym == plen_m1) state_nxt = PREAMBLE;
                PREAMBLE: if (sym == CNT_WIDTH'(5)) state_nxt = in_vld ? DATA : DUMMY;
`ifdef BL_ENCODER_CRC16_EN
                DATA:     state_nxt = dlast ? CRC : in_vld ? DATA : DUMMY;
                CRC:      if (sym == CNT_WIDTH'(15)) state_nxt = DUMMY;
`else
                DATA:     state_nxt = dlast ? DUMMY : in_vld ? DATA : DUMMY;
`endif
                DUMMY:    state_nxt = IDLE;
                default:  state_nxt = state;
            endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            out_bl <= 1'b0;
            underrun <= 1'b0;
            mode_q <= 2'b00;
            trext_q <= 1'b0;
            hl_q <= HALF_WIDTH'(1);
            scnt <= '0;
            hcnt <= '0;
            sym <= '0;
            lv <= 1'b0;
            prev <= 1'b1;
            dbit <= 1'b0;
            dlast <= 1'b0;
`ifdef BL_ENCODER_CRC16_EN
            crc <= 16'hFFFF;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                busy <= 1'b1;
                underrun <= 1'b0;
                mode_q <= mode;
                trext_q <= trext;
                hl_q <= half_len == '0 ? HALF_WIDTH'(1) : half_len;
                scnt <= '0;
                hcnt <= '0;
                sym <= '0;
                lv <= 1'b0;
                prev <= 1'b1;
`ifdef BL_ENCODER_CRC16_EN
                crc <= 16'hFFFF;
`endif
            end else if (strobe && busy) begin
                if (state == IDLE) begin
                    out_bl <= 1'b0;
                    busy <= 1'b0;
                end else begin
                    out_bl <= sample;
                    // FM0 data resumes from the preamble's final low level
                    lv <= (fm0 && state == PREAMBLE) ? 1'b0 : lv_n;
                    if (scnt == '0 && hcnt == '0)
                        prev <= d;
                    scnt <= last_smp ? '0 : scnt + CNT_WIDTH'(1);
                    if (last_smp)
                        hcnt <= hcnt == hmax ? '0 : hcnt + CNT_WIDTH'(1);
                    if (sym_end)
                        sym <= state_nxt != state ? '0 : sym + CNT_WIDTH'(1);
                    if (take) begin
                        dbit <= in_bit;
                        dlast <= in_last;
`ifdef BL_ENCODER_CRC16_EN
                        crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ in_bit) ? 16'h1021 : 16'h0000);
`endif
                    end
                    if (urun)
                        underrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bl_encoder.sv
// tb_bl_encoder: randomized frames compared sample-by-sample with a symbol-level reference model.
module tb_bl_encoder;
    logic clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, start = 1'b0, trext = 1'b0;
    logic in_bit = 1'b0, in_vld = 1'b0, in_last = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] half_len = 8'd1;
    logic in_rdy, out_bl, busy, underrun;
    int n_cmp = 0, n_err = 0;
    bit dat[$];
    bit expq[$];
    bit rdyq[$];

    bl_encoder dut (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .start(start), .mode(mode),
        .trext(trext), .half_len(half_len), .in_bit(in_bit), .in_vld(in_vld),
        .in_last(in_last), .in_rdy(in_rdy), .out_bl(out_bl), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected sample stream and in_rdy flags for one frame; u is the index of the
    // data bit whose request finds in_vld low (u >= dat.size() means no underrun).
    task automatic build(input logic [1:0] m, input bit tx, input int hl, input int u);
        bit sy[$], syr[$], hv[$], hr[$];
        bit b = 0, pv = 1;
        int n = dat.size();
        int mm = 1 << m;
        int npil = m == 0 ? (tx ? 12 : 0) : (tx ? 16 : 4);
        bit [5:0] mpre = 6'b010111;
        bit [11:0] fpre = 12'b110100100100;
        logic [15:0] c = 16'hFFFF;
        expq.delete();
        rdyq.delete();
        for (int j = 0; j < npil; j++) begin sy.push_back(0); syr.push_back(0); end
        if (m != 0)
            for (int j = 5; j >= 0; j--) begin sy.push_back(mpre[j]); syr.push_back(j == 0); end
        for (int j = 0; j < n && j < u; j++) begin
            sy.push_back(dat[j]);
            syr.push_back(j != n - 1);
            c = {c[14:0], 1'b0} ^ ((c[15] ^ dat[j]) ? 16'h1021 : 16'h0000);
        end
`ifdef BL_ENCODER_CRC16_EN
        if (u >= n)
            for (int j = 15; j >= 0; j--) begin sy.push_back(!c[j]); syr.push_back(0); end
`endif
        sy.push_back(1);
        syr.push_back(0);
        if (m == 0) begin
            for (int j = 0; j < sy.size(); j++) begin
                if (j == npil) begin
                    for (int k = 11; k >= 0; k--) begin hv.push_back(fpre[k]); hr.push_back(k == 0); end
                    b = 0;
                end
                b = !b; hv.push_back(b); hr.push_back(0);
                if (!sy[j]) b = !b;
                hv.push_back(b); hr.push_back(syr[j]);
            end
            for (int j = 0; j < hv.size(); j++)
                for (int i = 0; i < hl; i++) begin
                    expq.push_back(hv[j]);
                    rdyq.push_back(hr[j] && i == hl - 1);
                end
        end else begin
            for (int j = 0; j < sy.size(); j++) begin
                if (!pv && !sy[j]) b = !b;
                for (int i = 0; i < 2 * mm * hl; i++) begin
                    if (i == mm * hl && sy[j]) b = !b;
                    expq.push_back(b ^ ((i / hl) % 2 == 0));
                    rdyq.push_back(syr[j] && i == 2 * mm * hl - 1);
                end
                pv = sy[j];
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input bit tx, input logic [7:0] hlr, input int u, input int pct);
        int hl = hlr == 0 ? 1 : int'(hlr);
        int p = 0, k = 0, cyc = 0, len;
        bit s, xf;
        build(m, tx, hl, u);
        len = expq.size();
        @(negedge clk);
        mode = m; trext = tx; half_len = hlr; start = 1'b1;
        strobe = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("accept_busy", busy, 1);
        check("accept_underrun", underrun, 0);
        while (p <= len && cyc < 8000) begin
            @(negedge clk);
            start = cyc == 3;
            if (cyc == 3) begin
                mode = 2'($urandom_range(0, 3)); trext = 1'($urandom_range(0, 1)); half_len = 8'($urandom_range(0, 9));
            end
            strobe = $urandom_range(0, 99) < pct;
            in_vld = k < dat.size() && k != u;
            in_bit = k < dat.size() ? dat[k] : 1'b0;
            in_last = k == dat.size() - 1;
            check("in_rdy", in_rdy, p < len ? rdyq[p] : 1'b0);
            s = strobe;
            xf = in_rdy && strobe && in_vld;
            @(posedge clk); #1;
            cyc++;
            if (s) p++;
            if (xf) k++;
            check("out_bl", out_bl, (p == 0 || p > len) ? 1'b0 : expq[p - 1]);
            check("busy", busy, p <= len);
        end
        start = 1'b0; strobe = 1'b0; in_vld = 1'b0;
        check("frame_done", p, len + 1);
        check("xfers", k, u < dat.size() ? u : dat.size());
        check("underrun", underrun, u < dat.size());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, u;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_bl", out_bl, 0);
        check("rst_busy", busy, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dat = '{1, 0};       run_frame(2'd0, 1'b0, 8'd5, 99, 100);
        dat = '{1};          run_frame(2'd1, 1'b0, 8'd2, 99, 100);
        dat = '{0, 1, 1};    run_frame(2'd3, 1'b1, 8'd1, 99, 70);
        dat = '{1, 0, 1};    run_frame(2'd2, 1'b0, 8'd3, 0, 60);
        dat = '{1, 1, 0, 0}; run_frame(2'd0, 1'b1, 8'd0, 2, 80);
        // abort mid-preamble: 20 samples into a 36-sample FM0 preamble, currently high
        @(negedge clk);
        mode = 2'd0; trext = 1'b0; half_len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; strobe = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_out_bl", out_bl, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_bl", out_bl, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_rdy", in_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1; strobe = 1'b0;
        dat = '{0, 1};       run_frame(2'd1, 1'b1, 8'd2, 99, 90);
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 8);
            dat.delete();
            for (int j = 0; j < n; j++) dat.push_back(1'($urandom_range(0, 1)));
            u = $urandom_range(0, 3) == 0 ? $urandom_range(0, n - 1) : n;
            run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), u, $urandom_range(40, 100));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
